pic_merge_stream: RTL and testbench

//  Streaming sorted-index intersection unit for sparse mat-mult.

---
 rtl/pic_pkg.sv | 22 ++
 rtl/pic_pair_fifo.sv | 56 +++++
 rtl/pic_merge_stream.sv | 182 ++++++++++++++++++
 tb/tb_pic_merge_stream.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types for the sparse-intersection datapath: FSM states and the
// default matched-pair record used by control and FPU wrappers.
package pic_pkg;

    localparam int IDX_W_DEF = 16;
    localparam int VAL_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        MERGE,
        DRAIN_A,
        DRAIN_B,
        DONE
    } state_t;

    typedef struct packed {
        logic [IDX_W_DEF-1:0] idx;
        logic [VAL_W_DEF-1:0] a_val;
        logic [VAL_W_DEF-1:0] b_val;
    } pair_t;

endpackage

// File: rtl/pic_pair_fifo.sv
// Synchronous FIFO for matched pairs. Full/empty come from the registered
// occupancy count; pointers wrap naturally because DEPTH is a power of two.
module pic_pair_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = pic_pkg::pair_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  T                         i_din,
    input  logic                     i_pop,
    output T                         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_count;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage write; payload is not reset, only the bookkeeping is
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_din;
    end

    // Pointer and occupancy bookkeeping; simultaneous push+pop keeps the count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pic_merge_stream.sv
// Sorted-index intersection of two ascending (index,value) streams. Equal
// heads are pushed as pairs into an output FIFO; unequal heads advance the
// smaller side. Tracks match count and flags out-of-order indices.
module pic_merge_stream
    import pic_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int VAL_W = VAL_W_DEF,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [IDX_W-1:0] a_idx,
    input  logic [VAL_W-1:0] a_val,
    input  logic             a_last,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [IDX_W-1:0] b_idx,
    input  logic [VAL_W-1:0] b_val,
    input  logic             b_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [IDX_W-1:0] m_idx,
    output logic [VAL_W-1:0] m_a_val,
    output logic [VAL_W-1:0] m_b_val,
    output logic             busy,
    output logic             done,
    output logic [IDX_W:0]   match_cnt,
    output logic             err_order
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [VAL_W-1:0] a_val;
        logic [VAL_W-1:0] b_val;
    } pair_w_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_a_rdy;
    logic             w_b_rdy;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic             w_start_ok;
    logic             w_a_take;
    logic             w_b_take;
    pair_w_t          w_din;
    pair_w_t          w_dout;
    logic [IDX_W-1:0] r_a_prev;
    logic [IDX_W-1:0] r_b_prev;
    logic             r_a_seen;
    logic             r_b_seen;
    logic             r_err;
    logic [IDX_W:0]   r_cnt;

    function automatic logic [IDX_W:0] sat_inc(input logic [IDX_W:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_a_take   = w_a_rdy && a_valid;
    assign w_b_take   = w_b_rdy && b_valid;
    assign w_din      = '{idx: a_idx, a_val: a_val, b_val: b_val};
    assign w_pop      = !w_empty && m_ready;

    assign a_ready    = w_a_rdy;
    assign b_ready    = w_b_rdy;
    assign m_valid    = !w_empty;
    assign m_idx      = w_dout.idx;
    assign m_a_val    = w_dout.a_val;
    assign m_b_val    = w_dout.b_val;
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign match_cnt  = r_cnt;
    assign err_order  = r_err;

    pic_pair_fifo #(.DEPTH(DEPTH), .T(pair_w_t)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Head comparison, handshakes, pushes and next state
    always_comb begin
        w_next  = r_state;
        w_a_rdy = 1'b0;
        w_b_rdy = 1'b0;
        w_push  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = MERGE;
            end
            MERGE: begin
                if (a_valid && b_valid) begin
                    if (a_idx < b_idx) begin
                        w_a_rdy = 1'b1;
                    end else if (b_idx < a_idx) begin
                        w_b_rdy = 1'b1;
                    end else if (!w_full) begin
                        w_a_rdy = 1'b1;
                        w_b_rdy = 1'b1;
                        w_push  = 1'b1;
                    end
                end
                if (w_a_rdy && a_last && w_b_rdy && b_last) w_next = DONE;
                else if (w_a_rdy && a_last)                 w_next = DRAIN_B;
                else if (w_b_rdy && b_last)                 w_next = DRAIN_A;
            end
            DRAIN_A: begin
                w_a_rdy = a_valid;
                if (a_valid && a_last) w_next = DONE;
            end
            DRAIN_B: begin
                w_b_rdy = b_valid;
                if (b_valid && b_last) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Last consumed index per stream, used only by the order check
    always_ff @(posedge clk) begin
        if (w_a_take) r_a_prev <= a_idx;
        if (w_b_take) r_b_prev <= b_idx;
    end

    // Sticky order error; the first beat after start has no predecessor
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_seen <= 1'b0;
            r_b_seen <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_start_ok) begin
            r_a_seen <= 1'b0;
            r_b_seen <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_a_take) begin
                r_a_seen <= 1'b1;
                if (r_a_seen && (a_idx <= r_a_prev)) r_err <= 1'b1;
            end
            if (w_b_take) begin
                r_b_seen <= 1'b1;
                if (r_b_seen && (b_idx <= r_b_prev)) r_err <= 1'b1;
            end
        end
    end

    // Match counter, cleared by an accepted start and saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst)             r_cnt <= '0;
        else if (w_start_ok) r_cnt <= '0;
        else if (w_push)     r_cnt <= sat_inc(r_cnt);
    end

    // FIFO full flag must agree with its occupancy count
    always_ff @(posedge clk) begin
        if (!rst) assert (w_full == (w_count == FULL_CNT));
    end

endmodule

// File: tb/tb_pic_merge_stream.sv
// Directed bench for pic_merge_stream: a set-intersection model predicts the
// matched pairs, count and order flag; one process checks every FIFO pop.
module tb_pic_merge_stream;

    typedef struct {
        logic [15:0] idx;
        logic [31:0] av;
        logic [31:0] bv;
    } exp_t;

    logic        clk, rst, start;
    logic        a_valid, a_ready, a_last, b_valid, b_ready, b_last;
    logic [15:0] a_idx, b_idx, m_idx;
    logic [31:0] a_val, b_val, m_a_val, m_b_val;
    logic        m_valid, m_ready, busy, done, err_order;
    logic [16:0] match_cnt;

    logic [15:0] a_i [0:31];
    logic [15:0] b_i [0:31];
    logic [31:0] a_v [0:31];
    logic [31:0] b_v [0:31];
    logic [4:0]  a_n, b_n, a_ptr, b_ptr;
    logic        s_on, ptr_clr;

    int          a_src[$];
    int          b_src[$];
    exp_t        exp_q[$];
    int          obs_q[$];
    int          total, bad, done_cnt, d0, exp_cnt, exp_err;

    assign a_valid = s_on && (a_ptr < a_n);
    assign b_valid = s_on && (b_ptr < b_n);
    assign a_idx   = a_i[a_ptr];
    assign b_idx   = b_i[b_ptr];
    assign a_val   = a_v[a_ptr];
    assign b_val   = b_v[b_ptr];
    assign a_last  = (a_ptr == a_n - 5'd1);
    assign b_last  = (b_ptr == b_n - 5'd1);

    pic_merge_stream dut (
        .clk(clk), .rst(rst), .start(start),
        .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_val(a_val), .a_last(a_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_val(b_val), .b_last(b_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_idx(m_idx), .m_a_val(m_a_val), .m_b_val(m_b_val),
        .busy(busy), .done(done), .match_cnt(match_cnt), .err_order(err_order)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stream sources advance on each accepted beat
    always @(posedge clk) begin
        if (ptr_clr) begin
            a_ptr <= '0;
            b_ptr <= '0;
        end else begin
            if (a_valid && a_ready) a_ptr <= a_ptr + 5'd1;
            if (b_valid && b_ready) b_ptr <= b_ptr + 5'd1;
        end
    end

    // Compare process: every pop is checked against the model queue
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rst && m_valid && m_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected got idx=%0d want no output", m_idx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (m_idx !== e.idx || m_a_val !== e.av || m_b_val !== e.bv) begin
                    bad++;
                    $display("FAIL pair got=%0d/%h/%h want=%0d/%h/%h",
                             m_idx, m_a_val, m_b_val, e.idx, e.av, e.bv);
                end
            end
            obs_q.push_back(int'(m_idx));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    // Load streams and compute the expected intersection, count and order flag
    task automatic begin_vec();
        exp_t e;
        a_n = 5'(a_src.size());
        b_n = 5'(b_src.size());
        for (int k = 0; k < a_src.size(); k++) begin
            a_i[k] = 16'(a_src[k]);
            a_v[k] = 32'hA000_0000 | (32'(k) << 16) | 32'(a_src[k]);
        end
        for (int k = 0; k < b_src.size(); k++) begin
            b_i[k] = 16'(b_src[k]);
            b_v[k] = 32'hB000_0000 | (32'(k) << 16) | 32'(b_src[k]);
        end
        exp_cnt = 0;
        exp_err = 0;
        for (int i = 0; i < a_src.size(); i++)
            for (int j = 0; j < b_src.size(); j++)
                if (a_src[i] == b_src[j]) begin
                    e.idx = a_i[i];
                    e.av  = a_v[i];
                    e.bv  = b_v[j];
                    exp_q.push_back(e);
                    exp_cnt++;
                end
        for (int i = 1; i < a_src.size(); i++) if (a_src[i] <= a_src[i-1]) exp_err = 1;
        for (int j = 1; j < b_src.size(); j++) if (b_src[j] <= b_src[j-1]) exp_err = 1;
        obs_q.delete();
        d0 = done_cnt;
        ptr_clr = 1'b1;
        tick();
        ptr_clr = 1'b0;
        s_on    = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        @(negedge clk);
        chk("err_clear_on_start", 32'(err_order), 32'd0);
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic finish_vec();
        for (int k = 0; k < 300 && done_cnt == d0; k++) tick();
        chk("done_seen", 32'(done_cnt != d0), 32'd1);
        for (int k = 0; k < 100 && exp_q.size() > 0; k++) tick();
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("match_cnt", 32'(match_cnt), 32'(exp_cnt));
        chk("err_order", 32'(err_order), 32'(exp_err));
        chk("busy_idle", 32'(busy), 32'd0);
        chk("a_consumed", 32'(a_ptr), 32'(a_n));
        chk("b_consumed", 32'(b_ptr), 32'(b_n));
        tick();
        s_on = 1'b0;
    endtask

    task automatic wait_cnt(input int n);
        int k;
        for (k = 0; k < 60; k++) begin
            if (match_cnt == 17'(n)) break;
            @(negedge clk);
        end
        chk("wait_match_cnt", 32'(k < 60), 32'd1);
    endtask

    initial begin
        total = 0; bad = 0; done_cnt = 0;
        rst = 1'b1; start = 1'b0; m_ready = 1'b1; s_on = 1'b0; ptr_clr = 1'b1;
        a_n = '0; b_n = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_match_cnt", 32'(match_cnt), 32'd0);
        chk("rst_err", 32'(err_order), 32'd0);
        chk("rst_readys", 32'({a_ready, b_ready}), 32'd0);
        tick();
        rst = 1'b0;
        ptr_clr = 1'b0;

        // Basic intersection: indices 4 then 9
        a_src = {1, 4, 7, 9};
        b_src = {2, 4, 9, 12};
        begin_vec();
        finish_vec();
        chk("t1_n_out", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() == 2) begin
            chk("t1_first", 32'(obs_q[0]), 32'd4);
            chk("t1_second", 32'(obs_q[1]), 32'd9);
        end
        chk("t1_cnt_literal", 32'(match_cnt), 32'd2);

        // Single-element A, B drained after the match
        a_src = {3};
        b_src = {1, 2, 3, 5, 8};
        begin_vec();
        finish_vec();
        chk("t2_cnt_literal", 32'(match_cnt), 32'd1);

        // Out-of-order A: flag set, match still produced
        a_src = {5, 3, 6};
        b_src = {6};
        begin_vec();
        finish_vec();
        chk("t4_err_literal", 32'(err_order), 32'd1);
        chk("t4_first", 32'(obs_q.size() > 0 ? obs_q[0] : -1), 32'd6);

        // Next start clears the order flag
        a_src = {1, 4, 7, 9};
        b_src = {2, 4, 9, 12};
        begin_vec();
        finish_vec();

        // FIFO fills and stalls equal heads, then drains all ten
        a_src.delete();
        b_src.delete();
        for (int k = 0; k < 10; k++) begin
            a_src.push_back(k);
            b_src.push_back(k);
        end
        m_ready = 1'b0;
        begin_vec();
        repeat (15) tick();
        @(negedge clk);
        chk("t3_cnt_full", 32'(match_cnt), 32'd8);
        chk("t3_stall_readys", 32'({a_ready, b_ready}), 32'd0);
        chk("t3_m_valid", 32'(m_valid), 32'd1);
        chk("t3_head", 32'(m_idx), 32'd0);
        tick();
        m_ready = 1'b1;
        finish_vec();
        chk("t3_n_out", 32'(obs_q.size()), 32'd10);

        // Start while merging is ignored; push+pop at count 4 keeps it at 4
        a_src.delete();
        b_src.delete();
        for (int k = 0; k < 8; k++) begin
            a_src.push_back(k);
            b_src.push_back(k);
        end
        m_ready = 1'b0;
        begin_vec();
        wait_cnt(3);
        tick();
        m_ready = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        @(negedge clk);
        chk("t6_cnt_kept", 32'(match_cnt), 32'd5);
        chk("t6_head", 32'(m_idx), 32'd1);
        chk("t6_busy", 32'(busy), 32'd1);
        finish_vec();

        // Reset mid-merge with three queued pairs
        a_src.delete();
        b_src.delete();
        for (int k = 0; k < 10; k++) begin
            a_src.push_back(k);
            b_src.push_back(k);
        end
        m_ready = 1'b0;
        begin_vec();
        wait_cnt(2);
        tick();
        rst  = 1'b1;
        s_on = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t5_pre_cnt", 32'(match_cnt), 32'd3);
        chk("t5_pre_valid", 32'(m_valid), 32'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_m_valid", 32'(m_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_cnt", 32'(match_cnt), 32'd0);
        m_ready = 1'b1;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
